// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants and the FSM state type for the 8-way
// round-robin arbiter.
//   N_REQ       number of requesters
//   ID_W        width of an encoded requester index
//   arb_state_e arbiter FSM states (binary encoded)
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters and the arbiter.
//   req       requester -> arbiter, one level-sensitive bit per requester
//   gnt       one-hot grant
//   gnt_id    encoded index of the granted requester
//   gnt_valid any grant asserted
//   timeout   one-cycle pulse after a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_prio_enc8.sv
// rr_prio_enc8: rotated 8-to-3 priority encoder (combinational).
//   req_i  request vector
//   ptr_i  first index to consider; the search wraps upward mod 8
//   id_o   index of the first set bit at or above ptr_i (mod 8)
//   any_o  at least one request is set
module rr_prio_enc8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] shifted;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;

    // Rotate right by ptr so bit 0 of rot corresponds to requester ptr.
    assign dbl     = {req_i, req_i};
    assign shifted = dbl >> ptr_i;
    assign rot     = shifted[N_REQ-1:0];

    always_comb begin
        off = '0;
        casez (rot)
            8'b???????1: off = 3'd0;
            8'b??????10: off = 3'd1;
            8'b?????100: off = 3'd2;
            8'b????1000: off = 3'd3;
            8'b???10000: off = 3'd4;
            8'b??100000: off = 3'd5;
            8'b?1000000: off = 3'd6;
            8'b10000000: off = 3'd7;
            default:     off = 3'd0;
        endcase
    end

    // 3-bit add wraps the rotated offset back to an absolute index.
    assign id_o  = ptr_i + off;
    assign any_o = |req_i;

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with a bounded hold time.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter8_if.slave (req in; gnt, gnt_id, gnt_valid, timeout out)
// Parameter MAXHOLD (2..256): longest grant in cycles before forced release.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests from ptr upward
// GRANT | one requester owns the resource; hold counter running
// GAP   | one dead turnaround cycle after any release
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAXHOLD = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter8_if.slave bus
);

    localparam int              CNT_W     = $clog2(MAXHOLD + 1);
    localparam logic [CNT_W-1:0] MAXHOLD_C = CNT_W'(MAXHOLD);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [ID_W-1:0]  enc_id;
    logic             enc_any;
    logic             owner_req;

    rr_prio_enc8 u_enc (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .id_o  (enc_id),
        .any_o (enc_any)
    );

    assign owner_req = bus.req[gnt_id_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << enc_id;
                    gnt_id_d    = enc_id;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req || (cnt_q == MAXHOLD_C)) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + ID_W'(1);
                    cnt_d       = '0;
                    // Request still high here means the limit forced the release.
                    timeout_d   = owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: self-checking bench for rr_arbiter8 (MAXHOLD=4) and the
// standalone rotated priority encoder. Expected grants are queued before the
// stimulus runs and consumed by a monitor as each grant ends.
module tb_rr_arbiter8;

    logic clk;
    logic rst_n;

    rr_arbiter8_if bus_if ();

    rr_arbiter8 #(.MAXHOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    logic [7:0] enc_req;
    logic [2:0] enc_ptr;
    logic [2:0] enc_id;
    logic       enc_any;

    rr_prio_enc8 u_enc_tb (
        .req_i (enc_req),
        .ptr_i (enc_ptr),
        .id_o  (enc_id),
        .any_o (enc_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] id;
        int         len;
        logic       to;
        int         gap;   // idle cycles before this grant; -1 = don't care
    } exp_t;

    exp_t sb[$];

    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;

    // Grant monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        logic       in_g;
        int         len;
        int         idle_cnt;
        int         start_gap;
        logic [2:0] cur_id;
        logic [7:0] exp_gnt;
        exp_t       e;
        in_g = 1'b0; len = 0; idle_cnt = 1000; start_gap = 0; cur_id = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                in_g     = 1'b0;
                idle_cnt = 1000;
            end else begin
                exp_gnt = bus_if.gnt_valid ? (8'd1 << bus_if.gnt_id) : 8'd0;
                checks++;
                if (bus_if.gnt !== exp_gnt) begin
                    errors++;
                    $display("FAIL gnt_onehot: got %b expected %b", bus_if.gnt, exp_gnt);
                end
                if (bus_if.gnt_valid) begin
                    if (!in_g) begin
                        in_g = 1'b1; len = 1; cur_id = bus_if.gnt_id; start_gap = idle_cnt;
                    end else begin
                        len++;
                        checks++;
                        if (bus_if.gnt_id !== cur_id) begin
                            errors++;
                            $display("FAIL gnt_id_stable: got %0d expected %0d", bus_if.gnt_id, cur_id);
                        end
                    end
                    checks++;
                    if (bus_if.timeout !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_during_grant: got %b expected 0", bus_if.timeout);
                    end
                end else if (in_g) begin
                    in_g     = 1'b0;
                    idle_cnt = 1;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_grant: got id %0d len %0d expected none", cur_id, len);
                    end else begin
                        e = sb.pop_front();
                        if (cur_id !== e.id) begin
                            errors++;
                            $display("FAIL grant_id: got %0d expected %0d", cur_id, e.id);
                        end
                        checks++;
                        if (len != e.len) begin
                            errors++;
                            $display("FAIL grant_len id%0d: got %0d expected %0d", cur_id, len, e.len);
                        end
                        checks++;
                        if (bus_if.timeout !== e.to) begin
                            errors++;
                            $display("FAIL timeout_pulse id%0d: got %b expected %b", cur_id, bus_if.timeout, e.to);
                        end
                        if (e.gap >= 0) begin
                            checks++;
                            if (start_gap != e.gap) begin
                                errors++;
                                $display("FAIL grant_gap id%0d: got %0d expected %0d", cur_id, start_gap, e.gap);
                            end
                        end
                    end
                end else begin
                    idle_cnt++;
                    checks++;
                    if (bus_if.timeout !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_idle: got %b expected 0", bus_if.timeout);
                    end
                end
            end
        end
    end

    task automatic push(input logic [2:0] id, input int len, input logic to, input int gap);
        exp_t e;
        e.id = id; e.len = len; e.to = to; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        bus_if.req  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Drive req=r; each winner drops its request after 'hold' grant cycles
    // (hold=0: never drops). Ends when every queued grant has been observed.
    task automatic serve(input logic [7:0] r, input int hold);
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 1'b0;
        @(posedge clk); #1;
        bus_if.req = r;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                bus_if.req = '0;
                done = 1'b1;
                break;
            end
            if (bus_if.gnt_valid) begin
                cnt++;
                if (hold != 0 && cnt == hold) bus_if.req[bus_if.gnt_id] = 1'b0;
            end else begin
                cnt = 0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL serve_budget: got %0d grants outstanding expected 0", sb.size());
            sb.delete();
            bus_if.req = '0;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_prio_enc();
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 8; i++) begin
                enc_req = 8'd1 << i;
                enc_ptr = 3'(p);
                #1;
                checks++;
                if (enc_id !== 3'(i) || enc_any !== 1'b1) begin
                    errors++;
                    $display("FAIL enc_single p%0d: got id %0d any %b expected id %0d any 1", p, enc_id, enc_any, i);
                end
            end
            enc_req = 8'hFF;
            enc_ptr = 3'(p);
            #1;
            checks++;
            if (enc_id !== 3'(p)) begin
                errors++;
                $display("FAIL enc_all p%0d: got %0d expected %0d", p, enc_id, p);
            end
        end
        enc_req = 8'h00;
        #1;
        checks++;
        if (enc_any !== 1'b0) begin
            errors++;
            $display("FAIL enc_none: got %b expected 0", enc_any);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_if.gnt !== 8'h00 || bus_if.gnt_id !== 3'd0 ||
            bus_if.gnt_valid !== 1'b0 || bus_if.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got gnt %b id %0d v %b to %b expected all 0",
                     bus_if.gnt, bus_if.gnt_id, bus_if.gnt_valid, bus_if.timeout);
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        push(3'd0, 3, 1'b0, -1);
        serve(8'h01, 3);
        // ptr is now 1, so requester 1 wins ahead of requester 0.
        push(3'd1, 1, 1'b0, -1);
        push(3'd0, 1, 1'b0, 2);
        serve(8'h03, 1);
    endtask

    task automatic test_timeout();
        do_reset();
        push(3'd0, 4, 1'b1, -1);
        push(3'd7, 4, 1'b1, 2);
        push(3'd0, 4, 1'b1, 2);
        serve(8'h81, 0);
    endtask

    task automatic test_ptr_order();
        do_reset();
        push(3'd5, 1, 1'b0, -1);
        serve(8'h20, 1);
        push(3'd6, 1, 1'b0, -1);
        push(3'd1, 1, 1'b0, 2);
        serve(8'h42, 1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) push(3'(i), 1, 1'b0, (i == 0) ? -1 : 2);
        serve(8'hFF, 1);
        // ptr wrapped 7 -> 0, so requester 0 goes before requester 7.
        push(3'd0, 1, 1'b0, -1);
        push(3'd7, 1, 1'b0, 2);
        serve(8'h81, 1);
    endtask

    task automatic test_idle();
        bus_if.req = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.gnt_valid !== 1'b0 || bus_if.gnt !== 8'h00 || bus_if.timeout !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: got v %b gnt %b to %b expected 0",
                         bus_if.gnt_valid, bus_if.gnt, bus_if.timeout);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus_if.req = 8'h08;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (bus_if.gnt_valid !== 1'b1 || bus_if.gnt_id !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_grant: got v %b id %0d expected v 1 id 3",
                     bus_if.gnt_valid, bus_if.gnt_id);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.gnt !== 8'h00 || bus_if.gnt_id !== 3'd0 ||
            bus_if.gnt_valid !== 1'b0 || bus_if.timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt %b id %0d v %b to %b expected all 0",
                     bus_if.gnt, bus_if.gnt_id, bus_if.gnt_valid, bus_if.timeout);
        end
        bus_if.req = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push(3'd3, 1, 1'b0, -1);
        serve(8'h08, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus_if.req = '0;
        enc_req    = '0;
        enc_ptr    = '0;
        test_prio_enc();
        test_reset();
        test_single_hold();
        test_timeout();
        test_ptr_order();
        test_back_to_back();
        test_idle();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among 8 requesters. It uses a rotated 8-to-3 priority encoder to pick the next winner after the last served requester. The grant is held while the winner keeps its request high, up to a programmable maximum hold time. The block sits between the requester-side logic and the shared datapath and drives both a one-hot grant and the 3-bit encoded grant index.

## Interface
- MAXHOLD, 16: maximum number of consecutive cycles one grant stays asserted; must be 2..256.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request vector; bit i = requester i; level-sensitive, held until served.
- gnt  out  8  one-hot grant, registered.
- gnt_id  out  3  binary index of the granted requester, registered; meaningful only when gnt_valid=1.
- gnt_valid  out  1  high while any grant is asserted, registered.
- timeout  out  1  one-cycle pulse in the cycle after a grant is force-released by the MAXHOLD limit.

## Operation
- State machine has three states, IDLE, GRANT and GAP; encoding is binary.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: winner = first set bit scanning from ptr upward, mod 8.
  - Load gnt=1<<winner, gnt_id=winner, gnt_valid=1, hold count=1.
  - Go to GRANT.
- GRANT, req[gnt_id]=1 and count<MAXHOLD: stay in GRANT and increment count.
- GRANT, req[gnt_id]=0: release the grant.
- GRANT, count==MAXHOLD with req[gnt_id] still 1: force-release the grant and pulse timeout for 1 cycle.
- Release, both cases: gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod 8 with 3-bit wrap, go to GAP. gnt_id keeps its last value.
- GAP: one dead cycle with no grant, so the resource can turn around. Go to IDLE.
- A force-released requester stays eligible. Because ptr has moved past it, every other pending requester is served first.
- Changes on other req bits during GRANT are ignored.
- Reset, including mid-grant: state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0. Release takes effect immediately and asynchronously.

## Timing
- Request latency: req sampled in IDLE at edge t gives gnt/gnt_valid high after edge t (visible cycle t+1).
- Release latency: req[gnt_id] seen low at edge t gives gnt low after edge t.
- Per-grant cycle counts:
  - Minimum grant length is 1 cycle, when the request drops immediately.
  - Maximum grant length is MAXHOLD cycles.
- Back-to-back: minimum spacing between two grants is 2 cycles, one GAP cycle plus one IDLE arbitration cycle.
- timeout is high exactly in the cycle where gnt_valid first reads 0 after a forced release.
- All outputs are registered; there is no combinational path from req to outputs.
- Hold counter width is $clog2(MAXHOLD+1).

## Structure
- Package rr_arb_pkg contains:
  - N_REQ=8 and ID_W=3
  - the state enum {IDLE, GRANT, GAP}
- Sub-module rr_prio_enc8 is combinational:
  - Inputs are req[7:0] and ptr[2:0]; outputs are id[2:0] and any.
  - It rotates req right by ptr, priority-encodes the lowest set bit casex-style, then adds ptr mod 8.
  - It is verified standalone on all 8 single-bit inputs at each ptr value.
- The top level holds the FSM, ptr, the hold counter and the output registers.

## Test plan
- Reset then req=8'b0000_0001 held 3 cycles, then 0 -> gnt=8'b0000_0001, gnt_id=0 for 3 cycles; then GAP; ptr=1.
- req=8'b1000_0001 held constant, MAXHOLD=4 -> grants alternate id 0, id 7, id 0, each 4 cycles, separated by 2 idle cycles; timeout pulses after every grant.
- ptr=6 (after serving id 5), req=8'b0100_0010 -> gnt_id=6 first, then id 1; no reordering.
- req=8'b1111_1111, each winner drops its request after 1 cycle -> grant order is 0,1,2,…,7, then wraps to 0 (ptr 7->0).
- req=0 for 10 cycles -> gnt_valid=0, gnt=0 and timeout=0 throughout; no state change.
- rst_n pulled low mid-grant (gnt_id=3, count=2) -> outputs go to 0 immediately, without waiting for clk. After release, req=8'b0000_1000 gives gnt_id=3 again, since ptr=0 and id 3 is the first set bit.
